// File: rtl/multicycle_control_unit_if.sv
// Handshake and datapath-strobe bundle between the multi-cycle control unit and the rest of the core.
// The halted line only exists when CU_HALT_EN is defined.
interface multicycle_control_unit_if #(
    parameter int OP_W   = 4,
    parameter int REG_AW = 4,
    parameter int DISP_W = 8
);
    localparam int INS_W = OP_W + 3 * REG_AW;

    logic [INS_W-1:0]  ins;
    logic              ins_ack;
    logic              ins_req;
    logic              zero_flag;
    logic              mem_ack;
    logic              mem_req;
    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] dest_address;
    logic [REG_AW-1:0] source_b;
    logic [REG_AW-1:0] source_a;
    logic [DISP_W-1:0] disp;
    logic              alu_enable;
    logic              reg_write;
    logic              data_write;
    logic              data_select;
    logic              pc_write;
    logic              pc_jump_select;
    logic              ins_retire;
`ifdef CU_HALT_EN
    logic              halted;

    modport master (
        input  ins, ins_ack, zero_flag, mem_ack,
        output ins_req, mem_req, alu_op, dest_address, source_b, source_a, disp,
               alu_enable, reg_write, data_write, data_select, pc_write,
               pc_jump_select, ins_retire, halted
    );

    modport slave (
        output ins, ins_ack, zero_flag, mem_ack,
        input  ins_req, mem_req, alu_op, dest_address, source_b, source_a, disp,
               alu_enable, reg_write, data_write, data_select, pc_write,
               pc_jump_select, ins_retire, halted
    );
`else
    modport master (
        input  ins, ins_ack, zero_flag, mem_ack,
        output ins_req, mem_req, alu_op, dest_address, source_b, source_a, disp,
               alu_enable, reg_write, data_write, data_select, pc_write,
               pc_jump_select, ins_retire
    );

    modport slave (
        output ins, ins_ack, zero_flag, mem_ack,
        input  ins_req, mem_req, alu_op, dest_address, source_b, source_a, disp,
               alu_enable, reg_write, data_write, data_select, pc_write,
               pc_jump_select, ins_retire
    );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the register CPU, with wait-stated memories.
// Optional feature: define CU_HALT_EN to make opcode F a terminal HALT instead of a NOP.
module multicycle_control_unit #(
    parameter int OP_W   = 4,
    parameter int REG_AW = 4,
    parameter int DISP_W = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_control_unit_if.master bus
);
    localparam int INS_W = OP_W + 3 * REG_AW;

    localparam logic [OP_W-1:0] OP_ALU_LAST = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRANCH   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LOAD     = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STORE    = OP_W'(6);

    if (DISP_W != 2 * REG_AW) begin : g_bad_disp
        $error("DISP_W must equal 2*REG_AW");
    end
    if (OP_W < 3) begin : g_bad_op
        $error("OP_W must be at least 3 to encode the load/store/branch opcodes");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef CU_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [INS_W-1:0]  ir;
    logic              z_reg;

    logic [OP_W-1:0]   opcode;
    logic              is_alu;
    logic              is_branch;
    logic              is_load;
    logic              is_store;
    logic              is_halt;

    logic              ins_req_d;
    logic              mem_req_d;
    logic              alu_enable_d;
    logic              reg_write_d;
    logic              data_write_d;
    logic              data_select_d;
    logic              pc_write_d;
    logic              pc_jump_select_d;
    logic              ins_retire_d;
    logic              halted_d;

    assign opcode    = ir[INS_W-1 -: OP_W];
    assign is_alu    = (opcode <= OP_ALU_LAST);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
`ifdef CU_HALT_EN
    assign is_halt   = (opcode == {OP_W{1'b1}});
`else
    assign is_halt   = 1'b0;
`endif

    // IR only moves on an acked fetch; the flag only on an ALU execute, so branches reuse it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ir    <= '0;
            z_reg <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && bus.ins_ack) begin
                ir <= bus.ins;
            end
            if (state == S_EXEC && is_alu) begin
                z_reg <= bus.zero_flag;
            end
        end
    end

    always_comb begin
        next_state       = state;
        ins_req_d        = 1'b0;
        mem_req_d        = 1'b0;
        alu_enable_d     = 1'b0;
        reg_write_d      = 1'b0;
        data_write_d     = 1'b0;
        data_select_d    = 1'b0;
        pc_write_d       = 1'b0;
        pc_jump_select_d = 1'b0;
        ins_retire_d     = 1'b0;
        halted_d         = 1'b0;

        case (state)
            S_FETCH: begin
                ins_req_d = 1'b1;
                if (bus.ins_ack) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu || is_branch) begin
                    next_state = S_EXEC;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
`ifdef CU_HALT_EN
                end else if (is_halt) begin
                    next_state = S_HALT;
`endif
                end else begin
                    pc_write_d   = 1'b1;
                    ins_retire_d = 1'b1;
                    next_state   = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_enable_d = 1'b1;
                    next_state   = S_WB;
                end else if (is_branch) begin
                    pc_write_d       = 1'b1;
                    pc_jump_select_d = z_reg;
                    ins_retire_d     = 1'b1;
                    next_state       = S_FETCH;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_d     = 1'b1;
                data_write_d  = is_store;
                data_select_d = is_load;
                if (bus.mem_ack) begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                pc_write_d    = 1'b1;
                ins_retire_d  = 1'b1;
                reg_write_d   = is_alu || is_load;
                data_select_d = is_load;
                next_state    = S_FETCH;
            end
`ifdef CU_HALT_EN
            S_HALT: begin
                halted_d = 1'b1;
            end
`endif
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset forces FETCH, so ins_req is the only strobe that needs explicit gating.
    assign bus.ins_req        = ins_req_d & rst_n;
    assign bus.mem_req        = mem_req_d;
    assign bus.alu_enable     = alu_enable_d;
    assign bus.reg_write      = reg_write_d;
    assign bus.data_write     = data_write_d;
    assign bus.data_select    = data_select_d;
    assign bus.pc_write       = pc_write_d;
    assign bus.pc_jump_select = pc_jump_select_d;
    assign bus.ins_retire     = ins_retire_d;
`ifdef CU_HALT_EN
    assign bus.halted         = halted_d;
`endif

    assign bus.alu_op       = opcode;
    assign bus.dest_address = ir[INS_W-OP_W-1 -: REG_AW];
    assign bus.source_b     = ir[INS_W-OP_W-REG_AW-1 -: REG_AW];
    assign bus.source_a     = ir[REG_AW-1:0];
    assign bus.disp         = ir[DISP_W-1:0];

    logic unused_halt;
    assign unused_halt = is_halt ^ halted_d;
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle control unit for the team's accumulator-less register CPU. It fetches one instruction per handshake, decodes the opcode and register fields, and sequences the ALU, register-file, data-memory and PC strobes through a FETCH/DECODE/EXEC/MEM/WB state machine. It holds a registered zero flag and supports wait-stated instruction and data memories. It sits between the instruction memory, PC register, register file, ALU and data memory, and replaces the single-cycle combinational decoder.

## Interface
- `OP_W`, default 4: opcode width, taken from the instruction MSBs.
- `REG_AW`, default 4: register-address width. Instruction width is `INS_W = OP_W + 3*REG_AW`, which is 16 at defaults.
- `DISP_W`, default 8: displacement width. Must equal `2*REG_AW`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ins`  in  INS_W  instruction from instruction memory.
- `ins_ack`  in  1  instruction memory: `ins` is valid this cycle.
- `ins_req`  out  1  instruction fetch request.
- `zero_flag`  in  1  ALU zero result, valid in EXEC.
- `mem_ack`  in  1  data memory: access completes this cycle.
- `mem_req`  out  1  data memory request.
- `alu_op`  out  OP_W  IR opcode field.
- `dest_address`, `source_b`, `source_a`  out  REG_AW each  IR fields `[INS_W-OP_W-1 -: REG_AW]`, next field, low field.
- `disp`  out  DISP_W  IR `[DISP_W-1:0]`.
- `alu_enable`, `reg_write`, `data_write`, `data_select`, `pc_write`, `pc_jump_select`  out  1  datapath strobes.
- `ins_retire`  out  1  one-cycle pulse when an instruction completes.
- `halted`  out  1  the core is halted (only when `CU_HALT_EN` is defined).

## Operation
- Opcodes:
  - 0–3: ALU operations.
  - 4: branch-if-zero.
  - 5: load.
  - 6: store.
  - 7–E: NOP.
  - F: HALT when `CU_HALT_EN` is defined, otherwise NOP.
- Internal state:
  - IR (INS_W bits), loaded on `ins_ack` in FETCH.
  - `z_reg`, loaded from `zero_flag` in EXEC of ALU opcodes only.
- All field outputs are driven continuously from IR.
- Strobes are Moore outputs, decoded from state and IR opcode. A strobe is 0 in every state not listed for it.
- FETCH:
  - `ins_req=1`.
  - Stays in FETCH while `ins_ack=0`.
  - On `ins_ack=1`, loads IR and goes to DECODE.
- DECODE transitions:
  - ALU opcodes and branch → EXEC.
  - Load/store → MEM.
  - NOP → FETCH, with `pc_write=1` and `ins_retire=1`.
  - HALT → HALT.
- EXEC, ALU opcode:
  - `alu_enable=1`; capture `z_reg`.
  - Next state WB.
- EXEC, branch:
  - `pc_write=1`, `pc_jump_select=z_reg`, `ins_retire=1`.
  - Next state FETCH.
- MEM:
  - `mem_req=1`; `data_write=1` for store; `data_select=1` for load.
  - Holds while `mem_ack=0`.
  - On `mem_ack=1`, goes to WB.
- WB:
  - `pc_write=1`, `ins_retire=1`.
  - `reg_write=1` for ALU opcodes and load.
  - `data_select=1` for load.
  - Next state FETCH.
- HALT:
  - `halted=1`, all strobes 0.
  - Terminal until `rst_n` is asserted.
- `pc_jump_select` is 1 only in branch EXEC with `z_reg=1`. It is never asserted otherwise.

## Timing
- Reset (async, `rst_n=0`):
  - State=FETCH, IR=0, `z_reg=0`.
  - Every output is 0, including `ins_req`, which is gated by `rst_n`.
- First `ins_req` is in the first cycle with `rst_n=1`.
- Acks are sampled on the same edge as their request. A zero-wait memory gives one cycle per access.
- Zero-wait latency, `ins_req` cycle to `ins_retire`:
  - NOP: 2 cycles.
  - Branch: 3 cycles.
  - ALU, load, store: 4 cycles.
- Each wait cycle on either ack adds exactly one cycle.
- An ack outside its request state is ignored.
- `ins` and IR change only on an acked FETCH. The field outputs are stable from DECODE to retire.
- `z_reg` persists across branch, load, store and NOP. Consecutive branches use the same flag.
- Reset asserted mid-instruction (FETCH wait, MEM wait, or any state):
  - All outputs drop to 0 immediately.
  - No partial strobe occurs after `rst_n` rises.

## Configuration
- `CU_HALT_EN` defined:
  - Opcode F enters HALT and raises `halted`.
  - HALT does not pulse `ins_retire` and does not write the PC.
- `CU_HALT_EN` undefined:
  - Opcode F is a NOP.
  - No HALT state exists and the `halted` port is absent.

## Test plan
- Reset, then ALU instruction `0x1234`, `ins_ack` held high:
  - `ins_req` in cycle 1.
  - `alu_enable=1` with `alu_op=1` in cycle 3.
  - Cycle 4: `reg_write=1`, `dest_address=2`, `source_b=3`, `source_a=4`, `pc_write=1`, `ins_retire=1`.
- ALU instruction with `zero_flag=1` in EXEC, then branch `0x4005`:
  - `pc_jump_select=1`, `pc_write=1`, `disp=0x05`.
  - Repeat with `zero_flag=0` → `pc_jump_select=0`.
- Load `0x5A12`, `mem_ack` delayed 3 cycles:
  - `mem_req=1`, `data_write=0` for 4 cycles.
  - WB: `data_select=1`, `reg_write=1`, `dest_address=0xA`.
- Store `0x6012`, zero-wait:
  - MEM: `mem_req=1`, `data_write=1`.
  - WB: `reg_write=0`, `pc_write=1`.
- Pull `rst_n` low mid-MEM wait:
  - All outputs 0 in the same cycle.
  - After release, `ins_req=1` and the next instruction executes normally.
- `0xF000`:
  - With `CU_HALT_EN` → `halted=1`, no further `ins_req`.
  - Without it → NOP retire in 2 cycles.
